// File: rtl/fcl_pkg.sv
// Shared types and layer dimensions for the fully-connected layer sequencers.
package fcl_pkg;

    localparam int FCL1_NUM_IN  = 400;
    localparam int FCL1_NUM_OUT = 120;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } fcl_seq_state_t;

endpackage

// File: rtl/fcl_dly_line.sv
// DEPTH-stage 1-bit shift register with enable and synchronous flush.
// q is registered and reads 0 on any edge where the line is frozen.
module fcl_dly_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic flush,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sh_q;
    logic [DEPTH-1:0] sh_n;

    always_comb begin
        sh_n    = sh_q;
        sh_n[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            sh_n[i] = sh_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sh_q <= '0;
            q    <= 1'b0;
        end else if (en) begin
            sh_q <= sh_n;
            q    <= sh_n[DEPTH-1];
        end else begin
            q    <= 1'b0;
        end
    end

endmodule

// File: rtl/fcl_seq.sv
// Address/strobe sequencer for one fully-connected layer: CLR, NUM_IN reads,
// MEM_LAT drain, result write per neuron; pulses the busy-flag set/reset.
//   IDLE wait start | CLR clear acc | MAC issue reads | DRAIN wait for last product
//   WRITE emit neuron sum | DONE end-of-layer pulse
module fcl_seq
    import fcl_pkg::*;
#(
    parameter int NUM_IN  = FCL1_NUM_IN,
    parameter int NUM_OUT = FCL1_NUM_OUT,
    parameter int MEM_LAT = 1,
    parameter int IN_AW   = $clog2(NUM_IN),
    parameter int W_AW    = $clog2(NUM_IN * NUM_OUT),
    parameter int OUT_AW  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic              fcl_seq_clk,
    input  logic              fcl_seq_rst,
    input  logic              fcl_seq_en_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              rd_en_o,
    output logic [IN_AW-1:0]  in_addr_o,
    output logic [W_AW-1:0]   w_addr_o,
    output logic              acc_clr_o,
    output logic              acc_en_o,
    output logic              out_valid_o,
    output logic [OUT_AW-1:0] out_addr_o,
    output logic              flag_set_o,
    output logic              flag_clr_o,
    output logic              done_o
);

    localparam logic [IN_AW-1:0]  IN_LAST    = IN_AW'(NUM_IN - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST   = OUT_AW'(NUM_OUT - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(MEM_LAT - 1);

    fcl_seq_state_t    state_q, state_n;
    logic [IN_AW-1:0]  in_cnt_q, in_cnt_n;
    logic [W_AW-1:0]   w_addr_q, w_addr_n;
    logic [OUT_AW-1:0] neuron_q, neuron_n;
    logic [2:0]        drain_q, drain_n;
    logic              abort_hit;
    logic              set_n;

    always_comb begin
        state_n   = state_q;
        in_cnt_n  = in_cnt_q;
        w_addr_n  = w_addr_q;
        neuron_n  = neuron_q;
        drain_n   = drain_q;
        abort_hit = 1'b0;
        set_n     = 1'b0;
        if (state_q != IDLE && abort_i) begin
            abort_hit = 1'b1;
            state_n   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        set_n    = 1'b1;
                        in_cnt_n = '0;
                        w_addr_n = '0;
                        neuron_n = '0;
                        drain_n  = '0;
                        state_n  = CLR;
                    end
                end
                CLR: begin
                    drain_n = '0;
                    state_n = MAC;
                end
                MAC: begin
                    w_addr_n = w_addr_q + W_AW'(1);
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_n = '0;
                        state_n  = DRAIN;
                    end else begin
                        in_cnt_n = in_cnt_q + IN_AW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_n = WRITE;
                    end else begin
                        drain_n = drain_q + 3'd1;
                    end
                end
                WRITE: begin
                    drain_n = '0;
                    if (neuron_q == OUT_LAST) begin
                        state_n = DONE;
                    end else begin
                        neuron_n = neuron_q + OUT_AW'(1);
                        state_n  = CLR;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Strobes are registered from the next state; a frozen edge zeroes them
    // while the state and counters keep their value for resumption.
    always_ff @(posedge fcl_seq_clk) begin
        if (fcl_seq_rst) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            w_addr_q    <= '0;
            neuron_q    <= '0;
            drain_q     <= '0;
            rd_en_o     <= 1'b0;
            acc_clr_o   <= 1'b0;
            out_valid_o <= 1'b0;
            flag_set_o  <= 1'b0;
            flag_clr_o  <= 1'b0;
            done_o      <= 1'b0;
        end else if (fcl_seq_en_i) begin
            state_q     <= state_n;
            in_cnt_q    <= in_cnt_n;
            w_addr_q    <= w_addr_n;
            neuron_q    <= neuron_n;
            drain_q     <= drain_n;
            rd_en_o     <= (state_n == MAC);
            acc_clr_o   <= (state_n == CLR);
            out_valid_o <= (state_n == WRITE);
            flag_set_o  <= set_n;
            flag_clr_o  <= (state_n == DONE) || abort_hit;
            done_o      <= (state_n == DONE);
        end else begin
            rd_en_o     <= 1'b0;
            acc_clr_o   <= 1'b0;
            out_valid_o <= 1'b0;
            flag_set_o  <= 1'b0;
            flag_clr_o  <= 1'b0;
            done_o      <= 1'b0;
        end
    end

    assign in_addr_o  = in_cnt_q;
    assign w_addr_o   = w_addr_q;
    assign out_addr_o = neuron_q;

    // Fed from the held state decode so a freeze cannot drop an in-flight read.
    fcl_dly_line #(
        .DEPTH (MEM_LAT)
    ) u_acc_dly (
        .clk   (fcl_seq_clk),
        .rst   (fcl_seq_rst),
        .en    (fcl_seq_en_i),
        .flush (abort_hit && fcl_seq_en_i),
        .d     (state_q == MAC),
        .q     (acc_en_o)
    );

endmodule
